mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response/memory bundle for mem_arbiter.
// slave  : the arbiter side (takes requests, drives memory strobes).
// master : the environment side (requesters plus the synchronous-read memory).
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_stall;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_done;

  logic        err;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        owner;
  logic [1:0]  state;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done,
    output err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner, state
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done,
    input  err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner, state
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory port between the CPU and a
// debug/loader port. Each access is IDLE (arbitrate) -> ACC (strobe) -> RESP
// (deliver), so at most one access every three cycles. The CPU wins ties
// unless debug has lost STARVE_LIMIT arbitrations in a row.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  // +2 keeps the width non-zero even for STARVE_LIMIT = 0
  localparam int            CW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q;     // 0 = CPU, 1 = debug
  logic          lat_we;      // latched write qualifier of the in-flight access
  logic          lat_mis;     // latched misalignment of the in-flight access
  logic [CW-1:0] starve_cnt;  // debug arbitrations lost in a row

  logic          any_req;
  logic          dbg_win;
  logic          arb;
  logic          grant_we;
  logic          grant_mis;
  logic [31:0]   grant_addr;
  logic [31:0]   grant_wdata;
  logic          in_resp;
  logic [31:0]   rd_val;

  // Arbitration: pick the winner and mux its request fields
  always_comb begin
    any_req     = bus.cpu_req | bus.dbg_req;
    dbg_win     = bus.dbg_req & (~bus.cpu_req | (starve_cnt == LIMIT));
    arb         = (state_q == IDLE) & any_req;
    grant_we    = dbg_win ? bus.dbg_we    : bus.cpu_we;
    grant_addr  = dbg_win ? bus.dbg_addr  : bus.cpu_addr;
    grant_wdata = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
    grant_mis   = (grant_addr[1:0] != 2'b00);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: RESP always returns to IDLE so a held request is not re-counted
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = any_req ? ACC : IDLE;
      ACC:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant latch, starvation counter and registered memory strobes.
  // The strobes are loaded on the arbitration edge so they are high exactly
  // during ACC; a misaligned access never raises mem_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q       <= 1'b0;
      lat_we        <= 1'b0;
      lat_mis       <= 1'b0;
      starve_cnt    <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (arb) begin
      owner_q       <= dbg_win;
      lat_we        <= grant_we;
      lat_mis       <= grant_mis;
      bus.mem_en    <= ~grant_mis;
      bus.mem_we    <= ~grant_mis & grant_we;
      bus.mem_addr  <= grant_addr;
      bus.mem_wdata <= grant_wdata;
      if (dbg_win)
        starve_cnt <= '0;
      else if (bus.dbg_req && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + CW'(1);
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
    end
  end

  // Response steering: only the owner sees done/rdata, and only in RESP
  always_comb begin
    in_resp       = (state_q == RESP);
    rd_val        = (lat_we | lat_mis) ? 32'd0 : bus.mem_rdata;
    bus.cpu_done  = in_resp & ~owner_q;
    bus.dbg_done  = in_resp &  owner_q;
    bus.cpu_rdata = bus.cpu_done ? rd_val : 32'd0;
    bus.dbg_rdata = bus.dbg_done ? rd_val : 32'd0;
    bus.err       = in_resp & lat_mis;
    bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
    bus.owner     = owner_q;
    bus.state     = state_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a synchronous-read memory model, a transaction-level
// reference (word array + arbitration rule), directed scenarios and a
// randomized mixed-traffic run.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory seen by the DUT: word i starts at i*4, one-cycle read latency
  logic [31:0] mem [0:63];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 4);
      mem_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end
  end

  // Reference model: expected memory contents and debug starvation count
  logic [31:0] ref_mem [0:63];
  int          m_starve = 0;

  // One arbitration between pending requesters; returns 1 if debug wins
  function automatic bit model_arb(input bit c, input bit d);
    bit dw;
    dw = d && (!c || m_starve == LIMIT);
    if (dw) m_starve = 0;
    else if (d && m_starve < LIMIT) m_starve++;
    return dw;
  endfunction

  task automatic cpu_set(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dbg_set(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.dbg_req = r; bus.dbg_we = w; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_set(0, 0, 0, 0);
    dbg_set(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.state, bus.owner, bus.mem_en, bus.mem_we, bus.err, bus.cpu_done, bus.dbg_done} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {bus.state, bus.owner, bus.mem_en, bus.mem_we, bus.err, bus.cpu_done, bus.dbg_done});
    end
    checks++;
    if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_mem_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.cpu_rdata !== 32'd0 || bus.dbg_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", bus.cpu_rdata, bus.dbg_rdata);
    end
    bus.cpu_req = 1'b1; #1;
    checks++;
    if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi got %b exp 1", bus.cpu_stall); end
    bus.cpu_req = 1'b0; #1;
    checks++;
    if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo got %b exp 0", bus.cpu_stall); end
    @(negedge clk);
    reset = 1'b0;
    m_starve = 0;
  endtask

  task automatic test_cpu_read();
    cpu_set(1, 0, 32'h10, 0);
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10 || bus.state !== 2'd1) begin
      errors++; $display("FAIL rd_acc got en=%b we=%b a=%h st=%0d exp 1 0 10 1", bus.mem_en, bus.mem_we, bus.mem_addr, bus.state);
    end
    checks++;
    if (bus.cpu_done !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      errors++; $display("FAIL rd_acc_stall got done=%b stall=%b exp 0 1", bus.cpu_done, bus.cpu_stall);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== ref_mem[4]) begin
      errors++; $display("FAIL rd_resp got done=%b d=%h exp 1 %h", bus.cpu_done, bus.cpu_rdata, ref_mem[4]);
    end
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.mem_en !== 1'b0 || bus.err !== 1'b0 || bus.dbg_done !== 1'b0) begin
      errors++; $display("FAIL rd_resp_ctl got stall=%b en=%b err=%b ddone=%b exp 0 0 0 0", bus.cpu_stall, bus.mem_en, bus.err, bus.dbg_done);
    end
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd0 || bus.cpu_done !== 1'b0 || bus.cpu_rdata !== 32'd0) begin
      errors++; $display("FAIL rd_after got st=%0d done=%b d=%h exp 0 0 0", bus.state, bus.cpu_done, bus.cpu_rdata);
    end
  endtask

  task automatic test_dbg_write_cpu_read();
    int n;
    dbg_set(1, 1, 32'h8, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h8 ||
        bus.mem_wdata !== 32'hDEADBEEF || bus.owner !== 1'b1) begin
      errors++; $display("FAIL dw_acc got en=%b we=%b a=%h d=%h own=%b", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.owner);
    end
    @(negedge clk);
    checks++;
    if (bus.dbg_done !== 1'b1 || bus.dbg_rdata !== 32'd0 || bus.cpu_done !== 1'b0) begin
      errors++; $display("FAIL dw_resp got ddone=%b d=%h cdone=%b exp 1 0 0", bus.dbg_done, bus.dbg_rdata, bus.cpu_done);
    end
    dbg_set(0, 0, 0, 0);
    void'(model_arb(0, 1));
    ref_mem[2] = 32'hDEADBEEF;
    @(negedge clk);
    cpu_set(1, 0, 32'h8, 0);
    n = 0;
    while (bus.cpu_done !== 1'b1 && n < 6) begin @(negedge clk); n++; end
    checks++;
    if (n != 2) begin errors++; $display("FAIL dw_rd_latency got %0d exp 2", n); end
    checks++;
    if (bus.cpu_rdata !== ref_mem[2]) begin errors++; $display("FAIL dw_rd_data got %h exp %h", bus.cpu_rdata, ref_mem[2]); end
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int g = 0, cyc = 0, last = -1, dgr = 0;
    bit exp_d;
    cpu_set(1, 0, 32'h20, 0);
    dbg_set(1, 0, 32'h30, 0);
    while (g < 15 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (bus.cpu_done === 1'b1 || bus.dbg_done === 1'b1) begin
        exp_d = model_arb(1, 1);
        checks++;
        if ({bus.cpu_done, bus.dbg_done} !== (exp_d ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL starve_grant%0d got c=%b d=%b exp dbg=%b", g, bus.cpu_done, bus.dbg_done, exp_d);
        end
        checks++;
        if (exp_d) begin
          if (bus.dbg_rdata !== ref_mem[12]) begin errors++; $display("FAIL starve_ddata got %h exp %h", bus.dbg_rdata, ref_mem[12]); end
        end else begin
          if (bus.cpu_rdata !== ref_mem[8]) begin errors++; $display("FAIL starve_cdata got %h exp %h", bus.cpu_rdata, ref_mem[8]); end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin errors++; $display("FAIL starve_gap got %0d exp 3", cyc - last); end
        end
        last = cyc; g++;
        if (bus.dbg_done === 1'b1) dgr++;
      end
    end
    checks++;
    if (g != 15) begin errors++; $display("FAIL starve_timeout got %0d grants exp 15", g); end
    checks++;
    if (dgr != 3) begin errors++; $display("FAIL starve_dbg_count got %0d exp 3", dgr); end
    cpu_set(0, 0, 0, 0);
    dbg_set(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    int n;
    bit saw_en = 1'b0;
    cpu_set(1, 0, 32'h6, 0);
    n = 0;
    while (bus.cpu_done !== 1'b1 && n < 6) begin
      @(negedge clk); n++;
      if (bus.mem_en === 1'b1) saw_en = 1'b1;
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL mis_latency got %0d exp 2", n); end
    checks++;
    if (bus.err !== 1'b1 || bus.cpu_rdata !== 32'd0) begin
      errors++; $display("FAIL mis_resp got err=%b d=%h exp 1 0", bus.err, bus.cpu_rdata);
    end
    checks++;
    if (saw_en) begin errors++; $display("FAIL mis_mem_en got 1 exp 0"); end
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL mis_err_clear got %b exp 0", bus.err); end
    // misaligned debug write must not touch memory
    dbg_set(1, 1, 32'h9, 32'h12345678);
    n = 0;
    while (bus.dbg_done !== 1'b1 && n < 6) begin @(negedge clk); n++; end
    void'(model_arb(0, 1));
    checks++;
    if (bus.err !== 1'b1 || n != 2) begin errors++; $display("FAIL mis_wr_resp got err=%b lat=%0d exp 1 2", bus.err, n); end
    dbg_set(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (mem[2] !== ref_mem[2]) begin errors++; $display("FAIL mis_wr_suppress got %h exp %h", mem[2], ref_mem[2]); end
  endtask

  task automatic test_reset_mid_access();
    int  n;
    bit  saw = 1'b0;
    cpu_set(1, 0, 32'h14, 0);
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL rst_mid_acc got en=%b exp 1", bus.mem_en); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.state !== 2'd0 || bus.mem_addr !== 32'd0) begin
      errors++; $display("FAIL rst_mid_async got en=%b st=%0d a=%h exp 0 0 0", bus.mem_en, bus.state, bus.mem_addr);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.cpu_done === 1'b1 || bus.err === 1'b1 || bus.mem_en === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw) begin errors++; $display("FAIL rst_mid_quiet got activity exp none"); end
    checks++;
    if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall got %b exp 1", bus.cpu_stall); end
    reset = 1'b0;
    m_starve = 0;
    n = 0;
    while (bus.cpu_done !== 1'b1 && n < 6) begin @(negedge clk); n++; end
    checks++;
    if (n != 2) begin errors++; $display("FAIL rst_mid_reissue got %0d exp 2", n); end
    checks++;
    if (bus.cpu_rdata !== ref_mem[5]) begin errors++; $display("FAIL rst_mid_data got %h exp %h", bus.cpu_rdata, ref_mem[5]); end
    cpu_set(0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          cp, dp, exp_d, mis, w;
    logic        cw, dw;
    logic [31:0] ca, da, cd, dd, a, d, exp_r, got_r, oth_r;
    logic [5:0]  idx;
    int          cyc, diffs;
    for (int r = 0; r < 40; r++) begin
      do begin
        cp = 1'($urandom_range(0, 1));
        dp = 1'($urandom_range(0, 1));
      end while (!cp && !dp);
      cw = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      ca = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      da = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) ca[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) da[1:0] = 2'($urandom_range(1, 3));
      cd = $urandom;
      dd = $urandom;
      cpu_set(cp, cw, ca, cd);
      dbg_set(dp, dw, da, dd);
      cyc = 0;
      while ((cp || dp) && cyc < 12) begin
        @(negedge clk); cyc++;
        if (bus.cpu_done === 1'b1 || bus.dbg_done === 1'b1) begin
          exp_d = model_arb(cp, dp);
          if (exp_d) begin w = dw; a = da; d = dd; end
          else       begin w = cw; a = ca; d = cd; end
          mis   = (a[1:0] != 2'b00);
          idx   = a[7:2];
          exp_r = (mis || w) ? 32'd0 : ref_mem[idx];
          if (!mis && w) ref_mem[idx] = d;
          got_r = exp_d ? bus.dbg_rdata : bus.cpu_rdata;
          oth_r = exp_d ? bus.cpu_rdata : bus.dbg_rdata;
          checks++;
          if ({bus.cpu_done, bus.dbg_done} !== (exp_d ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL rnd%0d_grant got c=%b d=%b exp dbg=%b", r, bus.cpu_done, bus.dbg_done, exp_d);
          end
          checks++;
          if (got_r !== exp_r) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", r, got_r, exp_r); end
          checks++;
          if (oth_r !== 32'd0 || bus.err !== mis) begin
            errors++; $display("FAIL rnd%0d_side got other=%h err=%b exp 0 %b", r, oth_r, bus.err, mis);
          end
          checks++;
          if (bus.cpu_stall !== (cp && exp_d)) begin
            errors++; $display("FAIL rnd%0d_stall got %b exp %b", r, bus.cpu_stall, cp && exp_d);
          end
          if (exp_d) begin dp = 1'b0; bus.dbg_req = 1'b0; end
          else       begin cp = 1'b0; bus.cpu_req = 1'b0; end
        end else begin
          checks++;
          if (bus.cpu_rdata !== 32'd0 || bus.dbg_rdata !== 32'd0 || bus.err !== 1'b0 || bus.cpu_stall !== cp) begin
            errors++; $display("FAIL rnd%0d_quiet got c=%h d=%h err=%b stall=%b", r, bus.cpu_rdata, bus.dbg_rdata, bus.err, bus.cpu_stall);
          end
        end
      end
      checks++;
      if (cp || dp) begin
        errors++; $display("FAIL rnd%0d_timeout got pending c=%b d=%b exp none", r, cp, dp);
        cpu_set(0, 0, 0, 0);
        dbg_set(0, 0, 0, 0);
      end
      @(negedge clk);
    end
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
    checks++;
    if (diffs != 0) begin errors++; $display("FAIL rnd_mem_image got %0d differing words exp 0", diffs); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i * 4);
    test_reset();
    test_cpu_read();
    test_dbg_write_cpu_read();
    test_starvation();
    test_misaligned();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
